// File: rtl/sprite_blitter.sv
// sprite_blitter: multi-cycle CHIP-8 sprite blitter with an internal
// DISP_W x DISP_H monochrome frame buffer.
//
// Sprites are XOR-drawn one byte-wide row per clock as a read-modify-write
// of one VRAM row. Pixels that were already lit when a set sprite bit hits
// them raise the collision flag reported on vf. Off-screen pixels are
// either wrapped or clipped, selected per draw. A multi-cycle clear and a
// power-up clear zero one VRAM row per clock. A registered read port lets
// the display scanner fetch whole rows independently of blitter activity.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   clear_req         request a screen clear (sampled only when idle)
//   draw_req          request a sprite draw (sampled only when idle)
//   row, col          sprite start row (Vy) and column (Vx)
//   height            sprite height in rows (n), saturated to MAX_ROWS
//   wrap              1 = wrap off-screen pixels, 0 = clip them
//   sprite_data       sprite bytes, first row in the most significant byte
//   busy              operation in progress; requests are dropped
//   done              one-cycle pulse when a requested clear/draw completes
//   vf                collision result {7'b0, flag} of the last draw
//   rd_row, rd_data   scanner read port, one cycle latency, bit c = column c
module sprite_blitter #(
  parameter int DISP_W   = 64,
  parameter int DISP_H   = 32,
  parameter int MAX_ROWS = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear_req,
  input  logic                      draw_req,
  input  logic [7:0]                row,
  input  logic [7:0]                col,
  input  logic [7:0]                height,
  input  logic                      wrap,
  input  logic [MAX_ROWS*8-1:0]     sprite_data,
  output logic                      busy,
  output logic                      done,
  output logic [7:0]                vf,
  input  logic [$clog2(DISP_H)-1:0] rd_row,
  output logic [DISP_W-1:0]         rd_data
);

  localparam int RW = $clog2(DISP_H);          // VRAM row index width
  localparam int XW = $clog2(DISP_W);          // pixel column index width
  localparam int HW = $clog2(MAX_ROWS + 1);    // saturated height width
  localparam int CW = (RW > HW) ? RW : HW;     // shared row counter width
  localparam int SW = MAX_ROWS * 8;            // sprite buffer width

  typedef enum logic [2:0] {
    INIT_CLR,
    IDLE,
    CLEAR,
    DRAW,
    FIN
  } state_t;

  state_t            state, next_state;
  logic [CW-1:0]     cnt;        // row being cleared, or sprite row index
  logic [XW-1:0]     x0;
  logic [RW-1:0]     y0;
  logic [HW-1:0]     h;
  logic              wrap_q;
  logic [SW-1:0]     spr_q;      // shifted left one byte per drawn row
  logic              coll_acc;

  logic [DISP_W-1:0] vram [DISP_H];

  logic              accept_clear;
  logic              accept_draw;

  // Row datapath for the current sprite row.
  logic [7:0]        spr_byte;
  logic [RW:0]       y_sum;
  logic              y_over;
  logic [RW-1:0]     y_idx;
  logic              row_on;
  logic [DISP_W-1:0] old_row;
  logic [DISP_W-1:0] mask;
  logic              row_coll;

  // VRAM write port.
  logic              wr_en;
  logic [RW-1:0]     wr_idx;
  logic [DISP_W-1:0] wr_val;

  logic [DISP_W-1:0] rd_word;

  assign accept_clear = (state == IDLE) && clear_req;
  assign accept_draw  = (state == IDLE) && !clear_req && draw_req;

  // ---------------------------------------------------------------------
  // FSM next state and Moore outputs
  // ---------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default before the
  // case statement, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      INIT_CLR: begin
        if (cnt == CW'(DISP_H - 1)) next_state = IDLE;
      end
      IDLE: begin
        busy = 1'b0;
        if (accept_clear)      next_state = CLEAR;
        else if (accept_draw)  next_state = (height == 8'd0) ? FIN : DRAW;
      end
      CLEAR: begin
        if (cnt == CW'(DISP_H - 1)) next_state = FIN;
      end
      DRAW: begin
        if (cnt == CW'(h) - CW'(1)) next_state = FIN;
      end
      FIN: begin
        busy       = 1'b0;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = INIT_CLR;
    endcase
  end

  // ---------------------------------------------------------------------
  // Sprite row datapath
  // ---------------------------------------------------------------------
  assign spr_byte = spr_q[SW-1 -: 8];

  // Start row is already reduced mod DISP_H and the row index is below
  // MAX_ROWS, so one conditional subtract implements the vertical wrap.
  assign y_sum   = {1'b0, y0} + (RW + 1)'(cnt);
  assign y_over  = (y_sum >= (RW + 1)'(DISP_H));
  assign y_idx   = y_over ? RW'(y_sum - (RW + 1)'(DISP_H)) : RW'(y_sum);
  assign row_on  = !y_over || wrap_q;
  assign old_row = vram[y_idx];

  // Columns wrap with a single subtract as well; with DISP_W >= 8 the eight
  // target columns are distinct, so each pixel is hit at most once.
  always_comb begin
    logic [XW:0] cx;
    mask = '0;
    for (int j = 0; j < 8; j++) begin
      cx = {1'b0, x0} + (XW + 1)'(j);
      if (spr_byte[7-j]) begin
        if (cx < (XW + 1)'(DISP_W))
          mask[XW'(cx)] = 1'b1;
        else if (wrap_q)
          mask[XW'(cx - (XW + 1)'(DISP_W))] = 1'b1;
      end
    end
  end

  assign row_coll = row_on && |(old_row & mask);

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = '0;
    wr_val = '0;
    case (state)
      INIT_CLR, CLEAR: begin
        wr_en  = 1'b1;
        wr_idx = RW'(cnt);
      end
      DRAW: begin
        // Clipped rows still use their cycle but leave VRAM untouched.
        wr_en  = row_on;
        wr_idx = y_idx;
        wr_val = old_row ^ mask;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Frame buffer
  // ---------------------------------------------------------------------
  // NOTE: the VRAM array has no reset; it is zeroed row by row by the
  // INIT_CLR sequence, which keeps it mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) vram[wr_idx] <= wr_val;
  end

  generate
    if ((1 << RW) == DISP_H) begin : g_rd_full
      assign rd_word = vram[rd_row];
    end else begin : g_rd_guard
      assign rd_word = (rd_row < RW'(DISP_H)) ? vram[rd_row] : '0;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Control and datapath registers
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values; this is also what gives the read port
  // the old contents of a row written in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT_CLR;
      cnt      <= '0;
      x0       <= '0;
      y0       <= '0;
      h        <= '0;
      wrap_q   <= 1'b0;
      spr_q    <= '0;
      coll_acc <= 1'b0;
      vf       <= '0;
      rd_data  <= '0;
    end else begin
      state   <= next_state;
      rd_data <= rd_word;

      if ((next_state == state) &&
          (state == INIT_CLR || state == CLEAR || state == DRAW))
        cnt <= cnt + CW'(1);
      else
        cnt <= '0;

      if (accept_draw) begin
        x0       <= XW'(col % DISP_W);
        y0       <= RW'(row % DISP_H);
        h        <= (height > 8'(MAX_ROWS)) ? HW'(MAX_ROWS) : HW'(height);
        wrap_q   <= wrap;
        spr_q    <= sprite_data;
        coll_acc <= 1'b0;
        // A zero-height draw skips DRAW; its (empty) result lands here.
        if (height == 8'd0) vf <= '0;
      end

      if (state == DRAW) begin
        spr_q    <= spr_q << 8;
        coll_acc <= coll_acc | row_coll;
        // Loaded on entry to FIN so the flag is valid alongside done.
        if (next_state == FIN) vf <= {7'b0, coll_acc | row_coll};
      end
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter (64x32, 15-row sprites).
// A table of draw records is applied in order on a shared screen, each with
// hand-computed latency, vf and two VRAM rows; hand-written sequences cover
// power-up clear, clear/draw priority, requests while busy and mid-draw reset.
module tb_sprite_blitter;

  localparam int W  = 64;
  localparam int H  = 32;
  localparam int MR = 15;
  localparam int SW = MR * 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear_req;
  logic          draw_req;
  logic [7:0]    row, col, height;
  logic          wrap;
  logic [SW-1:0] sprite_data;
  logic          busy, done;
  logic [7:0]    vf;
  logic [4:0]    rd_row;
  logic [W-1:0]  rd_data;

  int n_checks = 0;
  int n_pass   = 0;

  sprite_blitter #(.DISP_W(W), .DISP_H(H), .MAX_ROWS(MR)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_req   (clear_req),
    .draw_req    (draw_req),
    .row         (row),
    .col         (col),
    .height      (height),
    .wrap        (wrap),
    .sprite_data (sprite_data),
    .busy        (busy),
    .done        (done),
    .vf          (vf),
    .rd_row      (rd_row),
    .rd_data     (rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic          clr;      // clear the screen before this draw
    logic [7:0]    col, row, height;
    logic          wrap;
    logic [SW-1:0] spr;
    int            lat;      // cycles from accept to done
    logic [7:0]    vf;
    logic [4:0]    r1;
    logic [W-1:0]  e1;
    logic [4:0]    r2;
    logic [W-1:0]  e2;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic clr, input logic [7:0] c, r, ht,
                              input logic wr, input logic [SW-1:0] spr,
                              input int lat, input logic [7:0] v,
                              input logic [4:0] r1, input logic [W-1:0] e1,
                              input logic [4:0] r2, input logic [W-1:0] e2);
    vec_t t;
    t.clr = clr; t.col = c; t.row = r; t.height = ht; t.wrap = wr;
    t.spr = spr; t.lat = lat; t.vf = v;
    t.r1 = r1; t.e1 = e1; t.r2 = r2; t.e2 = e2;
    return t;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    else
      n_pass++;
  endtask

  // Called at a negedge with a request already driven; drops the request
  // after the accepting edge and counts cycles until done.
  task automatic wait_done(input string name, input int exp_lat);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
      draw_req  = 1'b0;
      clear_req = 1'b0;
    end while (!done && k < 300);
    check({name, "_lat"}, 64'(k), 64'(exp_lat));
    @(negedge clk);
    check({name, "_done_pulse"}, {63'b0, done}, 64'd0);
    check({name, "_idle"}, {63'b0, busy}, 64'd0);
  endtask

  task automatic do_clear(input string name);
    clear_req = 1'b1;
    wait_done(name, 33);
  endtask

  task automatic read_row(input logic [4:0] r, output logic [W-1:0] d);
    rd_row = r;
    @(negedge clk);
    d = rd_data;
  endtask

  // Releases reset at a negedge and checks the power-up clear timing.
  task automatic release_and_init(input string name);
    int n = 0;
    logic saw = 1'b0;
    rst_n = 1'b1;
    while (busy && n < 200) begin
      if (done) saw = 1'b1;
      @(negedge clk);
      n++;
    end
    check({name, "_busy_cycles"}, 64'(n), 64'd32);
    check({name, "_no_done"}, {63'b0, saw}, 64'd0);
  endtask

  initial begin
    logic [W-1:0] d;
    int k;

    vecs[0] = mk(0, 0,  0,  1,  0, {8'hF0, 112'h0},  2, 8'h00, 0,  64'h000000000000000F, 1, 64'h0);
    vecs[1] = mk(0, 0,  0,  1,  0, {8'hF0, 112'h0},  2, 8'h01, 0,  64'h0,                1, 64'h0);
    vecs[2] = mk(0, 8,  0,  1,  0, {8'hF0, 112'h0},  2, 8'h00, 0,  64'h0000000000000F00, 1, 64'h0);
    vecs[3] = mk(1, 60, 31, 2,  0, {16'hFFFF, 104'h0}, 3, 8'h00, 31, 64'hF000000000000000, 0, 64'h0);
    vecs[4] = mk(1, 60, 31, 2,  1, {16'hFFFF, 104'h0}, 3, 8'h00, 31, 64'hF00000000000000F, 0, 64'hF00000000000000F);
    vecs[5] = mk(1, 70, 35, 1,  0, {8'h80, 112'h0},  2, 8'h00, 3,  64'h0000000000000040, 2, 64'h0);
    vecs[6] = mk(0, 0,  0,  20, 0, {15{8'h02}},     16, 8'h01, 14, 64'h0000000000000040, 15, 64'h0);
    vecs[7] = mk(0, 0,  0,  0,  0, {15{8'hFF}},      1, 8'h00, 0,  64'h0000000000000040, 1, 64'h0000000000000040);
    vecs[8] = mk(0, 62, 0,  1,  1, {8'hFF, 112'h0},  2, 8'h00, 0,  64'hC00000000000007F, 1, 64'h0000000000000040);
    vecs[9] = mk(0, 5,  0,  1,  0, {8'h80, 112'h0},  2, 8'h01, 0,  64'hC00000000000005F, 3, 64'h0);

    rst_n = 1'b0; clear_req = 1'b0; draw_req = 1'b0;
    row = '0; col = '0; height = '0; wrap = 1'b0; sprite_data = '0; rd_row = '0;

    // Reset values and power-up clear.
    repeat (3) @(negedge clk);
    check("rst_busy", {63'b0, busy}, 64'd1);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_vf", 64'(vf), 64'd0);
    check("rst_rd_data", rd_data, 64'd0);
    release_and_init("init");
    for (int r = 0; r < H; r++) begin
      read_row(5'(r), d);
      check($sformatf("init_row%0d", r), d, 64'd0);
    end
    check("init_vf", 64'(vf), 64'd0);

    // Table-driven draws on a shared screen.
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].clr) do_clear($sformatf("v%0d_clear", i));
      col = vecs[i].col; row = vecs[i].row; height = vecs[i].height;
      wrap = vecs[i].wrap; sprite_data = vecs[i].spr;
      check($sformatf("v%0d_ready", i), {63'b0, busy}, 64'd0);
      draw_req = 1'b1;
      wait_done($sformatf("v%0d", i), vecs[i].lat);
      check($sformatf("v%0d_vf", i), 64'(vf), 64'(vecs[i].vf));
      read_row(vecs[i].r1, d);
      check($sformatf("v%0d_row%0d", i, vecs[i].r1), d, vecs[i].e1);
      read_row(vecs[i].r2, d);
      check($sformatf("v%0d_row%0d", i, vecs[i].r2), d, vecs[i].e2);
    end

    // Clear wins over a simultaneous draw; a draw pulsed while busy is lost.
    col = 8'd10; row = 8'd10; height = 8'd1; wrap = 1'b0;
    sprite_data = {8'hFF, 112'h0};
    clear_req = 1'b1; draw_req = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      clear_req = 1'b0;
      draw_req  = (k == 5);
      if (k == 5) begin col = 8'd20; row = 8'd20; end
    end while (!done && k < 300);
    draw_req = 1'b0;
    check("prio_lat", 64'(k), 64'd33);
    @(negedge clk);
    check("prio_idle", {63'b0, busy}, 64'd0);
    check("prio_vf_kept", 64'(vf), 64'd1);
    read_row(5'd10, d);
    check("prio_row10", d, 64'd0);
    read_row(5'd20, d);
    check("busy_drop_row20", d, 64'd0);
    read_row(5'd0, d);
    check("prio_row0", d, 64'd0);

    // Reset in the middle of a draw.
    vecs[0] = mk(0, 0, 0, 1, 0, {8'hFF, 112'h0}, 2, 8'h01, 0, 64'hFF, 0, 64'hFF);
    col = 8'd0; row = 8'd0; height = 8'd1; sprite_data = {8'hFF, 112'h0};
    draw_req = 1'b1;
    wait_done("pre", 2);
    read_row(5'd0, d);
    check("pre_row0", d, 64'h00000000000000FF);
    height = 8'd15; sprite_data = {15{8'hFF}};
    draw_req = 1'b1;
    rd_row = 5'd1;
    repeat (5) begin
      @(negedge clk);
      draw_req = 1'b0;
    end
    check("mid_busy", {63'b0, busy}, 64'd1);
    check("mid_rd_nonzero", {63'b0, (rd_data != '0)}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {63'b0, busy}, 64'd1);
    check("mid_rst_done", {63'b0, done}, 64'd0);
    check("mid_rst_vf", 64'(vf), 64'd0);
    check("mid_rst_rd_data", rd_data, 64'd0);
    repeat (2) @(negedge clk);
    release_and_init("reinit");
    read_row(5'd0, d);
    check("reinit_row0", d, 64'd0);
    read_row(5'd1, d);
    check("reinit_row1", d, 64'd0);
    read_row(5'd3, d);
    check("reinit_row3", d, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
